// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : XGA (1024x768, 1344x806 total) timing constants, coordinate
//               type and a small range-decode helper for the VGA transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int c_coord_w = 11;
    typedef logic [c_coord_w-1:0] coord_t;

    localparam coord_t c_h_active     = 11'd1024;
    localparam coord_t c_h_front      = 11'd24;
    localparam coord_t c_h_sync       = 11'd136;
    localparam coord_t c_h_back       = 11'd160;
    localparam coord_t c_h_total      = c_h_active + c_h_front + c_h_sync + c_h_back;
    localparam coord_t c_h_sync_start = c_h_active + c_h_front;
    localparam coord_t c_h_sync_end   = c_h_sync_start + c_h_sync - 11'd1;

    localparam coord_t c_v_active     = 11'd768;
    localparam coord_t c_v_front      = 11'd3;
    localparam coord_t c_v_sync       = 11'd6;
    localparam coord_t c_v_back       = 11'd29;
    localparam coord_t c_v_total      = c_v_active + c_v_front + c_v_sync + c_v_back;
    localparam coord_t c_v_sync_start = c_v_active + c_v_front;
    localparam coord_t c_v_sync_end   = c_v_sync_start + c_v_sync - 11'd1;

    function automatic logic in_range(input coord_t val, input coord_t lo, input coord_t hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_delay.sv
`default_nettype none
// ============================================================================
// Module      : vga_delay
// Description : DEPTH-stage shift register with asynchronous active-low clear
//               to CLR_VAL; aligns sync/blank with the upstream pixel latency.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= CLR_VAL;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_tx.sv
`default_nettype none
// ============================================================================
// Module      : vga_tx
// Description : XGA timing generator and pixel output stage. Issues
//               coordinates upstream and realigns sync/blank with the colour
//               returned PIPE_DLY cycles later. Optional colour-bar pattern
//               is built in when VGA_TX_TEST_PATTERN_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_tx
    import vga_pkg::*;
#(
    parameter int   PIPE_DLY = 1,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic                 pclk,
    input  logic                 rst_n,
`ifdef VGA_TX_TEST_PATTERN_EN
    input  logic                 pattern_en,
`endif
    input  logic [3:0]           r_in,
    input  logic [3:0]           g_in,
    input  logic [3:0]           b_in,
    output logic [c_coord_w-1:0] hcount,
    output logic [c_coord_w-1:0] vcount,
    output logic                 hblnk,
    output logic                 vblnk,
    output logic                 frame_start,
    output logic                 hs,
    output logic                 vs,
    output logic [3:0]           r,
    output logic [3:0]           g,
    output logic [3:0]           b
);

`ifdef VGA_TX_TEST_PATTERN_EN
    localparam int c_dly_w = 6;
    localparam logic [c_dly_w-1:0] c_dly_clr = {~SYNC_POL, ~SYNC_POL, 1'b1, 3'b000};
`else
    localparam int c_dly_w = 3;
    localparam logic [c_dly_w-1:0] c_dly_clr = {~SYNC_POL, ~SYNC_POL, 1'b1};
`endif

    logic               r_run;
    coord_t             w_h_next;
    coord_t             w_v_next;
    logic               w_hs_int;
    logic               w_vs_int;
    logic               w_blank;
    logic [c_dly_w-1:0] w_dly_in;
    logic [c_dly_w-1:0] w_dly_out;
    logic               w_dly_hs;
    logic               w_dly_vs;
    logic               w_dly_blank;

    always_comb begin
        w_h_next = hcount + 11'd1;
        w_v_next = vcount;
        if (hcount == c_h_total - 11'd1) begin
            w_h_next = '0;
            w_v_next = (vcount == c_v_total - 11'd1) ? '0 : vcount + 11'd1;
        end
    end

    // The first edge after release only arms r_run, so (0,0) is held for one
    // full cycle and frame_start fires there; no partial frame ever resumes.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_run       <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (r_run) begin
                hcount      <= w_h_next;
                vcount      <= w_v_next;
                hblnk       <= (w_h_next >= c_h_active);
                vblnk       <= (w_v_next >= c_v_active);
                frame_start <= (w_h_next == '0) && (w_v_next == '0);
            end else begin
                frame_start <= 1'b1;
            end
        end
    end

    // Before r_run the coordinates hold their reset value, not a real pixel.
    assign w_hs_int = (r_run && in_range(hcount, c_h_sync_start, c_h_sync_end)) ? SYNC_POL : ~SYNC_POL;
    assign w_vs_int = (r_run && in_range(vcount, c_v_sync_start, c_v_sync_end)) ? SYNC_POL : ~SYNC_POL;
    assign w_blank  = hblnk | vblnk | ~r_run;

`ifdef VGA_TX_TEST_PATTERN_EN
    assign w_dly_in = {w_hs_int, w_vs_int, w_blank, hcount[9:7]};
`else
    assign w_dly_in = {w_hs_int, w_vs_int, w_blank};
`endif

    vga_delay #(
        .WIDTH   (c_dly_w),
        .DEPTH   (PIPE_DLY),
        .CLR_VAL (c_dly_clr)
    ) u_delay (
        .clk    (pclk),
        .rst_n  (rst_n),
        .i_data (w_dly_in),
        .o_data (w_dly_out)
    );

    assign w_dly_hs    = w_dly_out[c_dly_w-1];
    assign w_dly_vs    = w_dly_out[c_dly_w-2];
    assign w_dly_blank = w_dly_out[c_dly_w-3];

    // Final stage: PIPE_DLY delay stages plus this register give PIPE_DLY+1,
    // matching the upstream colour registered here exactly once.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hs <= ~SYNC_POL;
            vs <= ~SYNC_POL;
            r  <= 4'h0;
            g  <= 4'h0;
            b  <= 4'h0;
        end else begin
            hs <= w_dly_hs;
            vs <= w_dly_vs;
            if (w_dly_blank) begin
                r <= 4'h0;
                g <= 4'h0;
                b <= 4'h0;
`ifdef VGA_TX_TEST_PATTERN_EN
            end else if (pattern_en) begin
                r <= {4{w_dly_out[0]}};
                g <= {4{w_dly_out[1]}};
                b <= {4{w_dly_out[2]}};
`endif
            end else begin
                r <= r_in;
                g <= g_in;
                b <= b_in;
            end
        end
    end

endmodule
`default_nettype wire
